// File: rtl/regfile_rd_resp.sv
// regfile_rd_resp: general-purpose register file with two combinational read
// ports and one write port. After reset a sweep clears entries 1..DEPTH-1, one
// per cycle, while init_busy_o is high. Entry 0 has no storage and reads 0.
// Optional macro REGFILE_WR_BYPASS_EN forwards same-cycle write data to a read
// of the same non-zero address in RUN.
module regfile_rd_resp #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int SWEEP_START = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy_o,
    output logic [15:0]       wr_count_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_idx;
    logic [DATA_W-1:0] mem [1:DEPTH-1];
    logic              wr_accept;

    // A write only lands outside reset, in RUN, and to a non-zero address.
    assign wr_accept = !rst && (state == RUN) && we && (waddr != '0);

    // Sweep sequencer and saturating count of accepted writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SWEEP;
            sweep_idx  <= ADDR_W'(SWEEP_START);
            wr_count_o <= '0;
        end else begin
            if (state == SWEEP) begin
                sweep_idx <= sweep_idx + 1'b1;
                if (sweep_idx == LAST_IDX) begin
                    state <= RUN;
                end
            end
            if (wr_accept && (wr_count_o != 16'hFFFF)) begin
                wr_count_o <= wr_count_o + 16'd1;
            end
        end
    end

    // Array update: sweep clears one entry per cycle, RUN takes write-back data.
    // The reset edge itself leaves the contents alone.
    always_ff @(posedge clk) begin
        for (int i = 1; i < DEPTH; i++) begin
            if (!rst && (state == SWEEP) && (sweep_idx == ADDR_W'(i))) begin
                mem[i] <= '0;
            end else if (wr_accept && (waddr == ADDR_W'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] val;
        val = '0;
        if (!rst && (state == RUN) && re && (addr != '0)) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (addr == ADDR_W'(i)) begin
                    val = mem[i];
                end
            end
`ifdef REGFILE_WR_BYPASS_EN
            if (we && (waddr == addr)) begin
                val = wdata;
            end
`endif
        end
        return val;
    endfunction

    // Zero-latency read ports; busy follows reset combinationally.
    always_comb begin
        rdata1      = read_port(re1, raddr1);
        rdata2      = read_port(re2, raddr2);
        init_busy_o = rst || (state == SWEEP);
    end

endmodule

// File: tb/tb_regfile_rd_resp.sv
module tb_regfile_rd_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        init_busy_o;
    logic [15:0] wr_count_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_rd_resp dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .init_busy_o (init_busy_o),
        .wr_count_o  (wr_count_o)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts cycles of init_busy_o after rst is released, injecting a write
    // on sweep cycle inj_cycle (0 = none). Bounded at 100 cycles.
    task automatic run_sweep(input int inj_cycle, output int busy_cycles);
        busy_cycles = 0;
        while (init_busy_o && busy_cycles < 100) begin
            busy_cycles++;
            if (busy_cycles == inj_cycle) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
            end else begin
                we = 1'b0;
            end
            re1 = 1'b1; raddr1 = 5'd3;
            re2 = 1'b1; raddr2 = 5'd9;
            #1;
            chk("sweep_rd1_zero", rdata1, 32'h0);
            chk("sweep_rd2_zero", rdata2, 32'h0);
            @(negedge clk); #1;
        end
        we = 1'b0;
    endtask

    function automatic logic [31:0] byp(input logic [31:0] new_v, input logic [31:0] old_v);
`ifdef REGFILE_WR_BYPASS_EN
        return new_v;
`else
        return old_v;
`endif
    endfunction

    initial begin
        int bc;

        // {we, waddr, wdata, re1, raddr1, re2, raddr2, exp1, exp2, exp_cnt}
        vecs[0] = '{1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd5, 1'b0, 5'd5, 32'h0, 32'h0, 16'd0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_1234, 16'd1};
        vecs[2] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd5, 32'h0, 32'h0, 16'd1};
        vecs[3] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 1'b1, 5'd5, 32'h0, 32'h0000_1234, 16'd1};
        vecs[4] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd5,
                    byp(32'hA5A5_A5A5, 32'h0), 32'h0000_1234, 16'd1};
        vecs[5] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 16'd2};
        vecs[6] = '{1'b1, 5'd9, 32'h0000_0055, 1'b1, 5'd9, 1'b1, 5'd0,
                    byp(32'h55, 32'h0), 32'h0, 16'd2};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd9, 1'b1, 5'd3, 32'h55, 32'h0, 16'd3};
        vecs[8] = '{1'b1, 5'd5, 32'hCAFE_F00D, 1'b1, 5'd0, 1'b1, 5'd5,
                    32'h0, byp(32'hCAFE_F00D, 32'h0000_1234), 16'd3};
        vecs[9] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 1'b1, 5'd9, 32'hCAFE_F00D, 32'h55, 16'd4};

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd6;

        // Reset held for two edges
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", 32'(init_busy_o), 32'h1);
        chk("rst_rd1", rdata1, 32'h0);
        chk("rst_rd2", rdata2, 32'h0);
        chk("rst_cnt", 32'(wr_count_o), 32'h0);

        // Sweep with a dropped write on cycle 5
        @(negedge clk); rst = 1'b0; #1;
        run_sweep(5, bc);
        chk("sweep_len", 32'(bc), 32'd31);
        chk("sweep_done_busy", 32'(init_busy_o), 32'h0);
        chk("sweep_cnt", 32'(wr_count_o), 32'h0);

        for (int a = 1; a < 32; a++) begin
            re1 = 1'b1; raddr1 = 5'(a);
            re2 = 1'b1; raddr2 = 5'(31 - a + 1);
            #1;
            chk("post_sweep_rd1", rdata1, 32'h0);
            chk("post_sweep_rd2", rdata2, 32'h0);
        end

        // Table of RUN-state vectors, one per cycle
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
            re1 = vecs[v].re1; raddr1 = vecs[v].raddr1;
            re2 = vecs[v].re2; raddr2 = vecs[v].raddr2;
            #1;
            chk($sformatf("vec%0d_rd1", v), rdata1, vecs[v].exp1);
            chk($sformatf("vec%0d_rd2", v), rdata2, vecs[v].exp2);
            chk($sformatf("vec%0d_cnt", v), 32'(wr_count_o), 32'(vecs[v].exp_cnt));
        end

        // Mid-RUN reset with a pending write that must be dropped
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 5'd11; wdata = 32'h77;
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        chk("midrst_busy", 32'(init_busy_o), 32'h1);
        chk("midrst_rd1", rdata1, 32'h0);
        chk("midrst_rd2", rdata2, 32'h0);
        @(negedge clk); rst = 1'b0; we = 1'b0; #1;
        chk("midrst_cnt", 32'(wr_count_o), 32'h0);
        run_sweep(0, bc);
        chk("resweep_len", 32'(bc), 32'd31);
        re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd11; #1;
        chk("resweep_r9", rdata1, 32'h0);
        chk("resweep_r11", rdata2, 32'h0);
        chk("resweep_cnt", 32'(wr_count_o), 32'h0);

        // Counter saturation: 65535 writes reach FFFF, further writes hold it
        for (int n = 0; n < 65536; n++) begin
            @(negedge clk);
            we = 1'b1; waddr = 5'd1; wdata = 32'(n);
        end
        @(negedge clk); we = 1'b0; re1 = 1'b1; raddr1 = 5'd1; #1;
        chk("sat_cnt", 32'(wr_count_o), 32'h0000_FFFF);
        chk("sat_last_data", rdata1, 32'd65535);
        @(negedge clk); we = 1'b1; waddr = 5'd2; wdata = 32'h1; #1;
        @(negedge clk); we = 1'b0; #1;
        chk("sat_hold", 32'(wr_count_o), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
